// File: rtl/boxhead_pkg.sv
// Shared frame-buffer definitions for the copy engine and its pixel write sink.
// Holds screen geometry, the SRAM write record, the sink FSM states and the address helper.
package boxhead_pkg;

    localparam int H_RES     = 640;
    localparam int V_RES     = 480;
    localparam int FRAME_BIT = 19;
    localparam int ADDR_W    = 20;
    localparam int DATA_W    = 16;
    localparam int COORD_W   = 10;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } pixel_wr_t;

    typedef enum logic [1:0] {SINK_RUN, SINK_FLUSH, SINK_DONE} sink_state_e;

    // y*640 is built from two shifts so no multiplier is inferred.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic frame,
                                                     input logic [COORD_W-1:0] x,
                                                     input logic [COORD_W-1:0] y);
        logic [FRAME_BIT-1:0] y_w;
        logic [FRAME_BIT-1:0] lin;
        y_w = FRAME_BIT'(y);
        lin = (y_w << 9) + (y_w << 7) + FRAME_BIT'(x);
        return {frame, lin};
    endfunction

endpackage

// File: rtl/pixel_write_sink_if.sv
// Program-write bus between the copy engine, the pixel write sink and the SRAM controller.
// Handshake: program_write is a strobe that is taken only in a cycle where program_ready is high.
interface pixel_write_sink_if;
    import boxhead_pkg::*;

    logic [COORD_W-1:0] program_x;
    logic [COORD_W-1:0] program_y;
    logic [DATA_W-1:0]  program_data;
    logic               program_write;
    logic               current_frame;
    logic               frame_done;
    logic               program_ready;
    logic               flush_done;
    logic               write_slot;
    logic               sram_wr_en;
    logic [ADDR_W-1:0]  sram_wr_addr;
    logic [DATA_W-1:0]  sram_wr_data;
    logic               overflow;
    logic [7:0]         dropped_cnt;
    sink_state_e        sink_state;

    modport slave (
        input  program_x, program_y, program_data, program_write, current_frame,
        input  frame_done, write_slot,
        output program_ready, flush_done, sram_wr_en, sram_wr_addr, sram_wr_data,
        output overflow, dropped_cnt, sink_state
    );

    modport master (
        output program_x, program_y, program_data, program_write, current_frame,
        output frame_done, write_slot,
        input  program_ready, flush_done, sram_wr_en, sram_wr_addr, sram_wr_data,
        input  overflow, dropped_cnt, sink_state
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read and an occupancy count.
// Push while full is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/pixel_write_sink.sv
// Responder end of the copy engine's program-write bus: range-checks and addresses each pixel,
// queues it, drains the queue in granted SRAM write slots and handshakes frame flushes.
module pixel_write_sink
    import boxhead_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    pixel_write_sink_if.slave  bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0] READY_LIMIT = OCC_W'(FIFO_DEPTH - 2);

    sink_state_e        state;
    logic               ready_q;
    logic               flush_done_q;
    logic               overflow_q;
    logic [7:0]         dropped_q;

    logic               s1_valid;
    logic               s1_frame;
    logic [COORD_W-1:0] s1_x;
    logic [COORD_W-1:0] s1_y;
    logic [DATA_W-1:0]  s1_data;

    pixel_wr_t          fifo_wr;
    pixel_wr_t          fifo_rd;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;

    logic               wr_en_q;
    pixel_wr_t          wr_q;

    logic               accept;
    logic               in_range;
    logic               s1_next;
    logic               pop;
    logic [OCC_W-1:0]   occ_next;
    logic               room_ok;

    assign accept   = bus.program_write && ready_q;
    assign in_range = (bus.program_x < COORD_W'(H_RES)) && (bus.program_y < COORD_W'(V_RES));
    assign s1_next  = accept && in_range;
    assign pop      = bus.write_slot && !fifo_empty;
    assign fifo_wr  = '{addr: pixel_addr(s1_frame, s1_x, s1_y), data: s1_data};

    // Ready for next cycle only if one more write there would still leave the
    // FIFO plus S1 at or below FIFO_DEPTH-2, so nothing in flight can overrun.
    assign occ_next = OCC_W'(fifo_count) + OCC_W'(s1_valid) + OCC_W'(s1_next) - OCC_W'(pop);
    assign room_ok  = (occ_next < READY_LIMIT);

    sync_fifo #(
        .WIDTH ($bits(pixel_wr_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push    (s1_valid),
        .wr_data (fifo_wr),
        .pop     (pop),
        .rd_data (fifo_rd),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_frame <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= s1_next;
            if (accept) begin
                s1_frame <= bus.current_frame;
                s1_x     <= bus.program_x;
                s1_y     <= bus.program_y;
                s1_data  <= bus.program_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
            dropped_q  <= '0;
        end else begin
            if (bus.program_write && !ready_q) overflow_q <= 1'b1;
            if (accept && !in_range && (dropped_q != 8'hFF)) dropped_q <= dropped_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q <= 1'b0;
            wr_q    <= '0;
        end else begin
            wr_en_q <= pop;
            if (pop) wr_q <= fifo_rd;
        end
    end

    // FLUSH waits until S1 and the FIFO are both empty; the last pop has then
    // already been issued, so flush_done lands right after the final SRAM write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= SINK_RUN;
            ready_q      <= 1'b1;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            case (state)
                SINK_RUN: begin
                    if (bus.frame_done) begin
                        state   <= SINK_FLUSH;
                        ready_q <= 1'b0;
                    end else begin
                        ready_q <= room_ok;
                    end
                end
                SINK_FLUSH: begin
                    ready_q <= 1'b0;
                    if (!s1_valid && fifo_empty) begin
                        state        <= SINK_DONE;
                        flush_done_q <= 1'b1;
                    end
                end
                SINK_DONE: begin
                    state   <= SINK_RUN;
                    ready_q <= room_ok;
                end
                default: begin
                    state   <= SINK_RUN;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.program_ready = ready_q;
    assign bus.flush_done    = flush_done_q;
    assign bus.sram_wr_en    = wr_en_q;
    assign bus.sram_wr_addr  = wr_q.addr;
    assign bus.sram_wr_data  = wr_q.data;
    assign bus.overflow      = overflow_q;
    assign bus.dropped_cnt   = dropped_q;
    assign bus.sink_state    = state;

endmodule
